traffic_phase_ctrl: RTL and testbench

//  Parametrised two-road intersection sequencer: main/side R-Y-G lamps, per-phase dwell timers,
//  day/night mode. Advances only on a 1-per-second tick from an upstream prescaler.

---
 rtl/traffic_pkg.sv | 62 ++++++
 rtl/dwell_timer.sv | 34 +++
 rtl/traffic_phase_ctrl.sv | 152 +++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ============================================================================
// traffic_pkg : phase/lamp codes and dwell/lamp helpers for traffic_phase_ctrl
// Revision    : 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

  localparam logic [2:0] PH_ALLRED = 3'b111;
  localparam logic [2:0] PH_MG_SR  = 3'b000;
  localparam logic [2:0] PH_MY_SR  = 3'b001;
  localparam logic [2:0] PH_MR_SG  = 3'b010;
  localparam logic [2:0] PH_MR_SY  = 3'b011;
  localparam logic [2:0] PH_NIGHT  = 3'b100;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    ST_MG_SR  = PH_MG_SR,
    ST_MY_SR  = PH_MY_SR,
    ST_MR_SG  = PH_MR_SG,
    ST_MR_SY  = PH_MR_SY,
    ST_NIGHT  = PH_NIGHT,
    ST_ALLRED = PH_ALLRED
  } phase_t;

  // Dwell in ticks; a configured dwell of 0 still lasts one tick.
  function automatic int dwell_of(input logic [2:0] ph, input int t_ar, input int t_mg,
                                  input int t_my, input int t_sg, input int t_sy);
    int d;
    case (ph)
      PH_ALLRED: d = t_ar;
      PH_MG_SR:  d = t_mg;
      PH_MY_SR:  d = t_my;
      PH_MR_SG:  d = t_sg;
      PH_MR_SY:  d = t_sy;
      default:   d = 1;
    endcase
    return (d < 1) ? 1 : d;
  endfunction

  // Returns {main_lamp, side_lamp}.
  function automatic logic [5:0] lamps_of(input logic [2:0] ph, input logic flash);
    logic [5:0] l;
    case (ph)
      PH_ALLRED: l = {LAMP_R, LAMP_R};
      PH_MG_SR:  l = {LAMP_G, LAMP_R};
      PH_MY_SR:  l = {LAMP_Y, LAMP_R};
      PH_MR_SG:  l = {LAMP_R, LAMP_G};
      PH_MR_SY:  l = {LAMP_R, LAMP_Y};
      PH_NIGHT:  l = flash ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
      default:   l = {LAMP_R, LAMP_R};
    endcase
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// ============================================================================
// dwell_timer : loadable down-counter with zero flag, holds at zero
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dwell_timer #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] rst_val,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic [TW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= rst_val;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
// ============================================================================
// traffic_phase_ctrl : two-road R-Y-G sequencer with day/night mode and
//                      optional pedestrian request (define PED_REQ_EN)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TW    = 6,
  parameter int T_AR  = 2,
  parameter int T_MG  = 20,
  parameter int T_MY  = 3,
  parameter int T_SG  = 15,
  parameter int T_SY  = 3,
  parameter int T_PED = 5
) (
  input  logic          clk,
  input  logic          CR,
  input  logic          tick,
  input  logic          M,
  output logic [2:0]    main_lamp,
  output logic [2:0]    side_lamp,
  output logic [2:0]    phase,
  output logic [TW-1:0] remain
`ifdef PED_REQ_EN
  ,
  input  logic          ped_req,
  output logic          ped_walk
`endif
);

  // Reload value for a dwell of the given tick count, saturated to the timer width.
  function automatic logic [TW-1:0] load_of(input int ticks);
    int max_v;
    int r;
    max_v = (1 << TW) - 1;
    r     = ((ticks < 1) ? 1 : ticks) - 1;
    if (r > max_v) r = max_v;
    return r[TW-1:0];
  endfunction

  localparam logic [TW-1:0] c_ar  = load_of(T_AR);
  localparam logic [TW-1:0] c_ped = load_of(T_PED);

  phase_t        state;
  logic          flash;
  phase_t        w_next;
  logic          w_next_flash;
  logic          w_adv;
  logic          w_zero;
  logic          w_clamp;
  logic          w_ped_pending;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_dec;

`ifdef PED_REQ_EN
  logic ped_latch;
  assign w_ped_pending = ped_latch | ped_req;
`else
  assign w_ped_pending = 1'b0;
`endif

  dwell_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (CR),
    .rst_val  (c_ar),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .count    (remain),
    .zero     (w_zero)
  );

  always_comb begin
    w_next       = state;
    w_next_flash = flash;
    w_adv        = 1'b0;
    if (tick) begin
      if (state == ST_NIGHT) begin
        if (M) begin
          w_next       = ST_ALLRED;
          w_next_flash = 1'b0;
          w_adv        = 1'b1;
        end else begin
          w_next_flash = ~flash;
        end
      end else if (w_zero) begin
        w_adv = 1'b1;
        case (state)
          ST_ALLRED: w_next = M ? ST_MG_SR : ST_NIGHT;
          ST_MG_SR:  w_next = ST_MY_SR;
          ST_MY_SR:  w_next = M ? ST_MR_SG : ST_NIGHT;
          ST_MR_SG:  w_next = ST_MR_SY;
          ST_MR_SY:  w_next = M ? ST_MG_SR : ST_NIGHT;
          default:   w_next = ST_ALLRED;
        endcase
        // The entry tick counts as the first flash toggle, so NIGHT opens with lamps lit.
        if (w_next == ST_NIGHT) w_next_flash = ~flash;
      end
    end
  end

  assign w_clamp = w_ped_pending && (state == ST_MG_SR) && (remain > c_ped) && !w_adv;

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    if (w_adv) begin
      w_load     = 1'b1;
      w_load_val = (w_next == ST_NIGHT) ? '0
                 : load_of(dwell_of(w_next, T_AR, T_MG, T_MY, T_SG, T_SY));
    end else if (w_clamp) begin
      w_load     = 1'b1;
      w_load_val = c_ped;
    end else if (tick && !w_zero) begin
      w_dec = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      state                  <= ST_ALLRED;
      flash                  <= 1'b0;
      {main_lamp, side_lamp} <= {LAMP_R, LAMP_R};
`ifdef PED_REQ_EN
      ped_latch              <= 1'b0;
      ped_walk               <= 1'b0;
`endif
    end else begin
      state                  <= w_next;
      flash                  <= w_next_flash;
      {main_lamp, side_lamp} <= lamps_of(w_next, w_next_flash);
`ifdef PED_REQ_EN
      ped_walk               <= (w_next == ST_MR_SG);
      if (w_adv && (w_next == ST_MR_SG)) begin
        ped_latch <= 1'b0;
      end else if (ped_req) begin
        ped_latch <= 1'b1;
      end
`endif
    end
  end

  assign phase = state;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
// ============================================================================
// tb_traffic_phase_ctrl : directed bench with a phase/dwell reference model
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_traffic_phase_ctrl;

  localparam int TW    = 6;
  localparam int T_PED = 5;

  logic          clk = 1'b0;
  logic          CR;
  logic          tick;
  logic          M;
  logic [2:0]    main_lamp;
  logic [2:0]    side_lamp;
  logic [2:0]    phase;
  logic [TW-1:0] remain;
`ifdef PED_REQ_EN
  logic          ped_req;
  logic          ped_walk;
`endif

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk       (clk),
    .CR        (CR),
    .tick      (tick),
    .M         (M),
    .main_lamp (main_lamp),
    .side_lamp (side_lamp),
    .phase     (phase),
    .remain    (remain)
`ifdef PED_REQ_EN
    ,
    .ped_req   (ped_req),
    .ped_walk  (ped_walk)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase code, ticks left minus one, flash, pending pedestrian request.
  int dur [8];
  int m_ph    = 7;
  int m_rem   = 1;
  bit m_flash = 1'b0;
  bit m_lat   = 1'b0;

  initial begin
    for (int i = 0; i < 8; i++) dur[i] = 1;
    dur[7] = 2; dur[0] = 20; dur[1] = 3; dur[2] = 15; dur[3] = 3;
  end

  function automatic int next_of(input int p, input bit mode);
    case (p)
      7:       return mode ? 0 : 4;
      0:       return 1;
      1:       return mode ? 2 : 4;
      2:       return 3;
      3:       return mode ? 0 : 4;
      default: return 7;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int p, input bit f);
    case (p)
      0:       return 3'b001;
      1:       return 3'b010;
      4:       return f ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int p, input bit f);
    case (p)
      2:       return 3'b001;
      3:       return 3'b010;
      4:       return f ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int p0;
    int r0;
    bit req;
    bit moved;
    p0    = m_ph;
    r0    = m_rem;
    moved = 1'b0;
    req   = m_lat;
`ifdef PED_REQ_EN
    req   = req | ped_req;
`endif
    if (CR) begin
      m_ph = 7; m_rem = dur[7] - 1; m_flash = 1'b0; m_lat = 1'b0;
    end else begin
      if (tick) begin
        if (p0 == 4) begin
          if (M) begin
            m_ph = 7; m_rem = dur[7] - 1; m_flash = 1'b0; moved = 1'b1;
          end else begin
            m_flash = !m_flash;
          end
        end else if (r0 == 0) begin
          m_ph  = next_of(p0, M);
          moved = 1'b1;
          if (m_ph == 4) begin
            m_rem = 0; m_flash = !m_flash;
          end else begin
            m_rem = dur[m_ph] - 1;
          end
        end else begin
          m_rem = r0 - 1;
        end
      end
      if (req && p0 == 0 && r0 > T_PED - 1 && !moved) m_rem = T_PED - 1;
`ifdef PED_REQ_EN
      if (moved && m_ph == 2) m_lat = 1'b0;
      else if (ped_req)       m_lat = 1'b1;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("phase", phase, m_ph);
      check("remain", remain, m_rem);
      check("main_lamp", main_lamp, exp_main(m_ph, m_flash));
      check("side_lamp", side_lamp, exp_side(m_ph, m_flash));
`ifdef PED_REQ_EN
      check("ped_walk", ped_walk, (m_ph == 2));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ph(input int p, input int maxc, input string name);
    int k = 0;
    while (phase !== p[2:0] && k < maxc) begin
      step(1);
      k++;
    end
    check(name, phase, p);
  endtask

  initial begin : stim
    int n;
    int k;
    int ycnt;
    int w;
    bit seen;
    CR = 1'b1; tick = 1'b0; M = 1'b1;
`ifdef PED_REQ_EN
    ped_req = 1'b0;
`endif
    step(2);
    chk_en = 1'b1;
    check("reset_phase", phase, 7);
    check("reset_remain", remain, 1);
    check("reset_main", main_lamp, 3'b100);
    check("reset_side", side_lamp, 3'b100);

    CR = 1'b0; tick = 1'b1;
    step(2);
    check("first_mg_phase", phase, 0);
    check("first_mg_remain", remain, 19);
    check("first_mg_main", main_lamp, 3'b001);
    check("first_mg_side", side_lamp, 3'b100);

    n = 0; seen = 1'b0; ycnt = 0;
    do begin
      step(1);
      n++;
      if (phase != 3'd0) seen = 1'b1;
      if (phase == 3'd1 || phase == 3'd3) ycnt++;
    end while (!(seen && phase == 3'd0) && n < 100);
    check("day_loop_ticks", n, 41);
    check("yellow_cycles", ycnt, 6);

    step(4);
    check("pre_gap_remain", remain, 15);
    tick = 1'b0;
    step(10);
    check("gap_remain", remain, 15);
    check("gap_phase", phase, 0);
    tick = 1'b1;

`ifdef PED_REQ_EN
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    check("ped_clamp_remain", remain, 4);
    step(5);
    check("ped_my_entry", phase, 1);
    wait_ph(2, 10, "ped_reach_mr_sg");
    k = 0; w = 0;
    while (phase == 3'd2 && k < 40) begin
      if (ped_walk) w++;
      k++;
      step(1);
    end
    check("ped_walk_ticks", w, 15);
    check("mr_sg_ticks", k, 15);
`endif

    wait_ph(0, 100, "reach_mg_for_night");
    step(2);
    M = 1'b0;
    wait_ph(1, 40, "night_via_my");
    k = 0;
    while (phase == 3'd1 && k < 10) begin
      k++;
      step(1);
    end
    check("my_ticks_before_night", k, 3);
    check("night_phase", phase, 4);
    check("night_remain", remain, 0);
    check("night_lamp_lit", main_lamp, 3'b010);
    step(1);
    check("night_lamp_off", main_lamp, 3'b000);
    check("night_side_off", side_lamp, 3'b000);
    step(1);
    check("night_lamp_relit", side_lamp, 3'b010);
    M = 1'b1;
    step(1);
    check("night_exit_allred", phase, 7);
    check("night_exit_remain", remain, 1);
    k = 0;
    while (phase == 3'd7 && k < 10) begin
      k++;
      step(1);
    end
    check("allred_ticks", k, 2);
    check("after_allred_phase", phase, 0);

    wait_ph(2, 100, "reach_mr_sg_for_reset");
    step(3);
`ifdef PED_REQ_EN
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
`endif
    CR = 1'b1;
    step(1);
    check("cr_phase", phase, 7);
    check("cr_remain", remain, 1);
    check("cr_main", main_lamp, 3'b100);
    CR = 1'b0;
    wait_ph(0, 10, "restart_mg");
    step(1);
    check("restart_full_green", remain, 18);

    for (int i = 0; i < 400; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) M = ~M;
`ifdef PED_REQ_EN
      ped_req = ($urandom_range(0, 29) == 0);
`endif
      step(1);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
